// File: rtl/mem_ctrl.sv
// mem_ctrl: responder for LSB memory requests and instruction fetches.
//
// Each accepted request is serialized onto a byte-wide synchronous RAM bus,
// one byte per cycle, little-endian. Loads are sign- or zero-extended before
// being returned to the LSB; fetches always return a full 32-bit word. LSB
// requests take priority over fetches, and only one transaction is in flight.
//
// Handshake: ls_enable / if_enable are level requests, sampled only in IDLE.
// A request is accepted on the clock edge that ends a cycle in which the
// controller is IDLE, rdy_in is high, clear is low and neither finished pulse
// is high. Completion is a single-cycle ls_finished / if_finished pulse with
// the result valid in the same cycle. There is no back-pressure on the result.
//
// Optional feature (macro IO_STALL_EN): a store whose addr[17:16] == 2'b11
// holds off its first byte while io_buffer_full is high. Without the macro
// io_buffer_full is ignored.
//
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global freeze when low)
//   clear          pipeline flush
//   ls_enable, addr, lsb_type, store_val  -> LSB request
//   ls_finished, load_val                 -> LSB completion
//   if_enable, if_addr                    -> fetch request
//   if_finished, if_data                  -> fetch completion
//   mem_din, mem_dout, mem_a, mem_wr      -> byte RAM bus
//   io_buffer_full                        -> UART buffer status
//   dbg_state_o                           -> current FSM state
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              ls_enable,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        lsb_type,
  input  logic [31:0]       store_val,
  output logic              ls_finished,
  output logic [31:0]       load_val,
  input  logic              if_enable,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_finished,
  output logic [31:0]       if_data,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    FETCH = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        type_q;
  logic [31:0]       store_q;
  logic [31:0]       acc_q;
  logic [2:0]        len_q;
  logic [2:0]        idx_q;
  logic              clr_q;

  logic              ls_fin_q;
  logic              if_fin_q;
  logic [31:0]       load_val_q;
  logic [31:0]       if_data_q;
  logic [7:0]        mem_dout_q;
  logic [ADDR_W-1:0] mem_a_q;
  logic              mem_wr_q;

  logic [2:0]        idx_nx_d;
  logic [ADDR_W-1:0] addr_nx_d;
  logic [31:0]       acc_d;
  logic [31:0]       ext_d;
  logic [7:0]        byte_nx_d;
  logic [2:0]        req_len_d;
  logic              sample_ok_d;
  logic              io_block_d;

`ifdef IO_STALL_EN
  assign io_block_d = (addr[17:16] == 2'b11) && io_buffer_full;
`else
  logic unused_io;
  assign unused_io  = io_buffer_full;
  assign io_block_d = 1'b0;
`endif

  always_comb begin
    idx_nx_d  = idx_q + 3'd1;
    addr_nx_d = addr_q + ADDR_W'(idx_nx_d);

    // In LOAD/FETCH, idx_q counts cycles since the first address went out;
    // the byte arriving now belongs to address index idx_q-1.
    acc_d = acc_q;
    case (idx_q)
      3'd1:    acc_d[7:0]   = mem_din;
      3'd2:    acc_d[15:8]  = mem_din;
      3'd3:    acc_d[23:16] = mem_din;
      3'd4:    acc_d[31:24] = mem_din;
      default: ;
    endcase

    ext_d = acc_d;
    case (type_q[1:0])
      2'b00:   ext_d = type_q[2] ? {24'd0, acc_d[7:0]}  : {{24{acc_d[7]}}, acc_d[7:0]};
      2'b01:   ext_d = type_q[2] ? {16'd0, acc_d[15:0]} : {{16{acc_d[15]}}, acc_d[15:0]};
      default: ext_d = acc_d;
    endcase

    case (idx_nx_d)
      3'd1:    byte_nx_d = store_q[15:8];
      3'd2:    byte_nx_d = store_q[23:16];
      3'd3:    byte_nx_d = store_q[31:24];
      default: byte_nx_d = store_q[7:0];
    endcase

    case (lsb_type[1:0])
      2'b00:   req_len_d = 3'd1;
      2'b01:   req_len_d = 3'd2;
      default: req_len_d = 3'd4;
    endcase

    // The finished-pulse terms guarantee an IDLE gap after every completion.
    sample_ok_d = !clear && !ls_fin_q && !if_fin_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      type_q     <= '0;
      store_q    <= '0;
      acc_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      clr_q      <= 1'b0;
      ls_fin_q   <= 1'b0;
      if_fin_q   <= 1'b0;
      load_val_q <= '0;
      if_data_q  <= '0;
      mem_dout_q <= '0;
      mem_a_q    <= '0;
      mem_wr_q   <= 1'b0;
    end else if (rdy_in) begin
      ls_fin_q <= 1'b0;
      if_fin_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sample_ok_d && ls_enable) begin
            addr_q  <= addr;
            type_q  <= lsb_type;
            store_q <= store_val;
            len_q   <= req_len_d;
            idx_q   <= 3'd0;
            acc_q   <= '0;
            clr_q   <= 1'b0;
            if (lsb_type[3]) begin
              state_q <= STORE;
              if (io_block_d) begin
                // Byte 0 is held back until the UART buffer drains.
                mem_wr_q   <= 1'b0;
                mem_a_q    <= '0;
                mem_dout_q <= '0;
              end else begin
                mem_wr_q   <= 1'b1;
                mem_a_q    <= addr;
                mem_dout_q <= store_val[7:0];
              end
            end else begin
              state_q  <= LOAD;
              mem_wr_q <= 1'b0;
              mem_a_q  <= addr;
            end
          end else if (sample_ok_d && if_enable) begin
            state_q  <= FETCH;
            addr_q   <= if_addr;
            type_q   <= 4'b0010;
            len_q    <= 3'd4;
            idx_q    <= 3'd0;
            acc_q    <= '0;
            clr_q    <= 1'b0;
            mem_wr_q <= 1'b0;
            mem_a_q  <= if_addr;
          end
        end

        LOAD, FETCH: begin
          if (clear) begin
            // Abort: partial data is dropped and no completion is reported.
            state_q <= IDLE;
            idx_q   <= 3'd0;
            mem_a_q <= '0;
          end else begin
            acc_q <= acc_d;
            if (idx_q == len_q) begin
              state_q <= IDLE;
              idx_q   <= 3'd0;
              if (state_q == LOAD) begin
                ls_fin_q   <= 1'b1;
                load_val_q <= ext_d;
              end else begin
                if_fin_q  <= 1'b1;
                if_data_q <= acc_d;
              end
            end else begin
              idx_q   <= idx_nx_d;
              mem_a_q <= (idx_nx_d < len_q) ? addr_nx_d : '0;
            end
          end
        end

        STORE: begin
          // A flush cannot cancel a store already on the bus; it only
          // silences the completion pulse.
          clr_q <= clr_q | clear;
          if (!mem_wr_q) begin
            if (!io_buffer_full) begin
              mem_wr_q   <= 1'b1;
              mem_a_q    <= addr_q;
              mem_dout_q <= store_q[7:0];
            end
          end else if (idx_q == len_q - 3'd1) begin
            state_q    <= IDLE;
            idx_q      <= 3'd0;
            mem_wr_q   <= 1'b0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            ls_fin_q   <= !(clr_q | clear);
            load_val_q <= '0;
          end else begin
            idx_q      <= idx_nx_d;
            mem_a_q    <= addr_nx_d;
            mem_dout_q <= byte_nx_d;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign ls_finished = ls_fin_q;
  assign load_val    = load_val_q;
  assign if_finished = if_fin_q;
  assign if_data     = if_data_q;
  assign mem_dout    = mem_dout_q;
  assign mem_a       = mem_a_q;
  assign mem_wr      = mem_wr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed plus randomized bench for mem_ctrl. A byte RAM model sits on the
// memory bus; a separate reference image plus a per-transaction schedule give
// the expected bus trace, completion pulses and returned data.
module tb_mem_ctrl;

`ifdef IO_STALL_EN
  localparam int STALL_LEN = 5;
`else
  localparam int STALL_LEN = 0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear;
  logic        ls_enable;
  logic [31:0] addr;
  logic [3:0]  lsb_type;
  logic [31:0] store_val;
  logic        ls_finished;
  logic [31:0] load_val;
  logic        if_enable;
  logic [31:0] if_addr;
  logic        if_finished;
  logic [31:0] if_data;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic [1:0]  dbg_state;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .ls_enable(ls_enable), .addr(addr), .lsb_type(lsb_type), .store_val(store_val),
    .ls_finished(ls_finished), .load_val(load_val),
    .if_enable(if_enable), .if_addr(if_addr),
    .if_finished(if_finished), .if_data(if_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- RAM environment ----------------
  logic [7:0] ram     [int unsigned];
  logic [7:0] ref_mem [int unsigned];

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  always @(posedge clk_in) begin
    if (mem_wr) ram[mem_a] = mem_dout;
    mem_din <= ram_rd(mem_a);
  end

  // ---------------- reference model ----------------
  // kind: 0 = LSB load, 1 = LSB store, 2 = fetch
  typedef struct {
    int          kind;
    int          n;
    logic [31:0] a;
    logic [31:0] sv;
    int          t0;
    int          clr;
    int          stall;
  } txn_t;

  txn_t        txns[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          clear_at = -1;
  int          io_until = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h cyc=%0d", tag, obs, exp_v, cyc);
    end
  endtask

  // Registers a transaction accepted at the end of cycle t0 and derives its
  // result and memory effect directly from the access-type rules.
  task automatic add_txn(input int kind, input logic [3:0] t, input logic [31:0] a,
                         input logic [31:0] sv, input int clr, input int stall);
    txn_t        x;
    longint      v;
    logic [31:0] res;
    bit          completes;
    x.kind  = kind;
    x.n     = (kind == 2) ? 4 : (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
    x.a     = a;
    x.sv    = sv;
    x.t0    = cyc;
    x.clr   = clr;
    x.stall = stall;
    v = 0;
    if (kind == 1) begin
      for (int i = 0; i < x.n; i++) ref_mem[a + 32'(i)] = sv[8*i +: 8];
      res = 32'd0;
      completes = !(clr >= 1 && clr <= stall + x.n);
    end else begin
      for (int i = 0; i < x.n; i++) v = v + (longint'({56'd0, ref_rd(a + 32'(i))}) << (8*i));
      if (kind == 0 && !t[2] && v >= (longint'(1) << (8*x.n - 1))) v = v - (longint'(1) << (8*x.n));
      res = v[31:0];
      completes = !(clr >= 1 && clr <= x.n + 1);
    end
    if (completes) exp_q.push_back(res);
    txns.push_back(x);
    if (txns.size() > 4) void'(txns.pop_front());
    if (clr > 0) clear_at = cyc + clr;
  endtask

  function automatic void expect_at(input int c, output logic e_wr, output logic [31:0] e_a,
                                    output logic [7:0] e_d, output logic e_lsf, output logic e_iff);
    e_wr = 1'b0; e_a = '0; e_d = '0; e_lsf = 1'b0; e_iff = 1'b0;
    foreach (txns[j]) begin
      int k, n, s, cl;
      logic [31:0] tmp;
      k  = c - txns[j].t0;
      n  = txns[j].n;
      s  = txns[j].stall;
      cl = txns[j].clr;
      if (txns[j].kind == 1) begin
        if (k >= s + 1 && k <= s + n) begin
          e_wr = 1'b1;
          e_a  = txns[j].a + 32'(k - s - 1);
          tmp  = txns[j].sv >> (8*(k - s - 1));
          e_d  = tmp[7:0];
        end
        if (k == s + n + 1 && !(cl >= 1 && cl <= s + n)) e_lsf = 1'b1;
      end else begin
        if (k >= 1 && k <= n && (cl == 0 || k <= cl)) e_a = txns[j].a + 32'(k - 1);
        if (k == n + 2 && !(cl >= 1 && cl <= n + 1)) begin
          if (txns[j].kind == 0) e_lsf = 1'b1;
          else                   e_iff = 1'b1;
        end
      end
    end
  endfunction

  // Checks the current cycle at the falling edge, then advances one cycle.
  task automatic step();
    logic        e_wr, e_lsf, e_iff;
    logic [31:0] e_a, v;
    logic [7:0]  e_d;
    bit          frozen;
    expect_at(cyc, e_wr, e_a, e_d, e_lsf, e_iff);
    @(negedge clk_in);
    chk("mem_wr", {31'd0, mem_wr}, {31'd0, e_wr});
    chk("mem_a", mem_a, e_a);
    if (e_wr) chk("mem_dout", {24'd0, mem_dout}, {24'd0, e_d});
    chk("ls_finished", {31'd0, ls_finished}, {31'd0, e_lsf});
    chk("if_finished", {31'd0, if_finished}, {31'd0, e_iff});
    if (ls_finished === 1'b1 || if_finished === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_finish observed=pulse expected=none cyc=%0d", cyc);
      end
      if (exp_q.size() != 0) begin
        v = exp_q.pop_front();
        if (ls_finished === 1'b1) chk("load_val", load_val, v);
        else                      chk("if_data", if_data, v);
      end
    end
    @(posedge clk_in);
    frozen = (rdy_in == 1'b0);
    #1;
    cyc++;
    if (frozen) foreach (txns[j]) txns[j].t0++;
    clear          = (cyc == clear_at);
    io_buffer_full = (cyc < io_until);
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    ls_enable = 1'b0;
    if_enable = 1'b0;
    repeat (n) step();
  endtask

  task automatic issue(input int kind, input logic [3:0] t, input logic [31:0] a,
                       input logic [31:0] sv, input int clr, input int stall, input int hold);
    if (kind == 2) begin
      if_enable = 1'b1;
      if_addr   = a;
    end else begin
      ls_enable = 1'b1;
      addr      = a;
      lsb_type  = t;
      store_val = sv;
    end
    add_txn(kind, t, a, sv, clr, stall);
    step();
    ls_enable = 1'b0;
    if_enable = 1'b0;
    // Request inputs wander during the transaction and must be ignored.
    addr      = $urandom;
    lsb_type  = 4'($urandom_range(0, 15));
    store_val = $urandom;
    if_addr   = $urandom;
    repeat (hold) step();
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]     = b;
    ref_mem[a] = b;
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] type_tab [8];

  initial begin
    type_tab[0] = 4'b0000; type_tab[1] = 4'b0001; type_tab[2] = 4'b0010;
    type_tab[3] = 4'b0100; type_tab[4] = 4'b0101; type_tab[5] = 4'b1000;
    type_tab[6] = 4'b1001; type_tab[7] = 4'b1010;

    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; ls_enable = 1'b0; addr = '0;
    lsb_type = '0; store_val = '0; if_enable = 1'b0; if_addr = '0;
    io_buffer_full = 1'b0;

    // Reset state
    #1 rst_in = 1'b1;
    #2;
    chk("rst_ls_finished", {31'd0, ls_finished}, 32'd0);
    chk("rst_load_val", load_val, 32'd0);
    chk("rst_if_finished", {31'd0, if_finished}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    cyc = 0;

    preload(32'h100, 8'h78); preload(32'h101, 8'h56);
    preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    preload(32'h20, 8'h80);  preload(32'h21, 8'hFF);
    idle(2);

    // Word, byte and half loads with both extensions
    issue(0, 4'b0010, 32'h100, 0, 0, 0, 8);
    issue(0, 4'b0000, 32'h20, 0, 0, 0, 4);
    issue(0, 4'b0100, 32'h20, 0, 0, 0, 4);
    issue(0, 4'b0001, 32'h20, 0, 0, 0, 5);
    issue(0, 4'b0101, 32'h20, 0, 0, 0, 5);

    // Half store, then neighbour byte untouched and readback
    issue(1, 4'b1001, 32'h200, 32'hAABBCCDD, 0, 0, 4);
    chk("ram_0x202_untouched", {24'd0, ram_rd(32'h202)}, {24'd0, init_byte(32'h202)});
    issue(0, 4'b0010, 32'h200, 0, 0, 0, 8);

    // Held request: no sampling in the completion cycle, resampled right after
    ls_enable = 1'b1; addr = 32'h20; lsb_type = 4'b0000;
    add_txn(0, 4'b0000, 32'h20, 0, 0, 0);
    step();
    addr = 32'h101; lsb_type = 4'b0100;
    repeat (3) step();
    add_txn(0, 4'b0100, 32'h101, 0, 0, 0);
    step();
    idle(5);

    // Both requesters at once: LSB first, fetch accepted after the gap cycle
    ls_enable = 1'b1; addr = 32'h100; lsb_type = 4'b0010;
    if_enable = 1'b1; if_addr = 32'h200;
    add_txn(0, 4'b0010, 32'h100, 0, 0, 0);
    step();
    ls_enable = 1'b0;
    repeat (6) step();
    add_txn(2, 4'b0010, 32'h200, 0, 0, 0);
    step();
    idle(8);

    // Flush during a load aborts; flush during a store commits silently
    issue(0, 4'b0010, 32'h100, 0, 2, 0, 8);
    issue(1, 4'b1010, 32'h300, 32'h11223344, 2, 0, 6);
    issue(0, 4'b0010, 32'h300, 0, 0, 0, 8);

    // Flush in IDLE blocks sampling for that cycle only
    clear_at = cyc; clear = 1'b1;
    ls_enable = 1'b1; addr = 32'h400; lsb_type = 4'b1000; store_val = 32'h0000_00C3;
    step();
    add_txn(1, 4'b1000, 32'h400, 32'h0000_00C3, 0, 0);
    step();
    idle(5);

    // Global freeze while idle with requests pending, then in mid-store
    rdy_in = 1'b0; ls_enable = 1'b1; if_enable = 1'b1;
    addr = 32'h600; lsb_type = 4'b1010; if_addr = 32'h100;
    repeat (3) step();
    rdy_in = 1'b1; ls_enable = 1'b0; if_enable = 1'b0;
    step();
    ls_enable = 1'b1; addr = 32'h500; lsb_type = 4'b1010; store_val = 32'hCAFEF00D;
    add_txn(1, 4'b1010, 32'h500, 32'hCAFEF00D, 0, 0);
    step();
    ls_enable = 1'b0;
    step();
    rdy_in = 1'b0;
    repeat (2) step();
    rdy_in = 1'b1;
    repeat (7) step();

    // UART-region store with a full buffer for five cycles
    io_until = cyc + 5; io_buffer_full = 1'b1;
    issue(1, 4'b1000, 32'h0003_0000, 32'h0000_005A, 0, STALL_LEN, 9);
    chk("ram_uart_byte", {24'd0, ram_rd(32'h0003_0000)}, 32'h5A);

    // Asynchronous reset in the middle of a load
    ls_enable = 1'b1; addr = 32'h100; lsb_type = 4'b0010;
    add_txn(0, 4'b0010, 32'h100, 0, 0, 0);
    step();
    ls_enable = 1'b0;
    step();
    rst_in = 1'b1;
    #1;
    chk("async_rst_mem_a", mem_a, 32'd0);
    chk("async_rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    txns.delete();
    exp_q.delete();
    cyc++;
    idle(2);

    // Word load across the top of the address space
    issue(0, 4'b0010, 32'hFFFF_FFFE, 0, 0, 0, 8);

    // Randomized mix
    for (int r = 0; r < 40; r++) begin
      int sel, kind, n, clr;
      logic [3:0]  t;
      logic [31:0] a;
      sel  = $urandom_range(0, 8);
      kind = (sel == 8) ? 2 : (type_tab[sel][3] ? 1 : 0);
      t    = (sel == 8) ? 4'b0010 : type_tab[sel];
      n    = (kind == 2) ? 4 : (t[1:0] == 2'b00) ? 1 : (t[1:0] == 2'b01) ? 2 : 4;
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else                           a = 32'h1000 + 32'($urandom_range(0, 31));
      clr = 0;
      if ($urandom_range(0, 5) == 0) clr = (kind == 1) ? $urandom_range(1, n) : $urandom_range(1, n + 1);
      issue(kind, t, a, $urandom, clr, 0, 8);
      idle($urandom_range(0, 2));
    end

    // Memory image written through the bus must match the reference image
    foreach (ref_mem[k]) chk("ram_image", {24'd0, ram_rd(k)}, {24'd0, ref_mem[k]});
    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL missing_finish observed=%0d_pending expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
